conv_encoder_punct: RTL

- 802.11a transmit-side convolutional encoder: K=7, rate-1/2 mother code, generators g0=133 (octal) and g1=171 (octal).
- Optional puncturing to rate 2/3 or 3/4.
- Serial coded-bit output with valid/ready flow control.
- Sits between scrambler/tail-insertion and interleaver. It produces the A/B coded stream that the Viterbi ACS path (branch-metric/error adders) consumes.

---
 rtl/conv_encoder_punct_pkg.sv | 24 ++
 rtl/conv_enc_core.sv | 17 +
 rtl/conv_encoder_punct.sv | 80 ++++++++
 3 files changed

// File: rtl/conv_encoder_punct_pkg.sv
// conv_encoder_punct_pkg: shared PHY constants (rate codes, K=7 generators, puncture tables)
package conv_encoder_punct_pkg;
  localparam logic [1:0] RATE_1_2 = 2'd0;
  localparam logic [1:0] RATE_2_3 = 2'd1;
  localparam logic [1:0] RATE_3_4 = 2'd2;
  localparam logic [6:0] GEN_A_DEF = 7'o133;
  localparam logic [6:0] GEN_B_DEF = 7'o171;
  typedef struct packed {
    logic emit_a;
    logic emit_b;
  } punct_t;
  function automatic logic [1:0] rate_norm(input logic [1:0] r);
    return r == 2'd3 ? RATE_1_2 : r;
  endfunction
  function automatic punct_t punct_lookup(input logic [1:0] r, input logic [1:0] ph);
    return r == RATE_2_3 ? (ph == 2'd1 ? punct_t'(2'b10) : punct_t'(2'b11)) :
           r == RATE_3_4 ? (ph == 2'd1 ? punct_t'(2'b10) : ph == 2'd2 ? punct_t'(2'b01) : punct_t'(2'b11)) :
           punct_t'(2'b11);
  endfunction
  function automatic logic [1:0] ph_next(input logic [1:0] r, input logic [1:0] ph);
    return r == RATE_2_3 ? (ph == 2'd1 ? 2'd0 : ph + 2'd1) :
           r == RATE_3_4 ? (ph == 2'd2 ? 2'd0 : ph + 2'd1) : 2'd0;
  endfunction
endpackage

// File: rtl/conv_enc_core.sv
// conv_enc_core: combinational K=7 encoder; ports in_bit_i, sr_i[5:0] (sr_i[5] newest) -> a_o, b_o
module conv_enc_core
  import conv_encoder_punct_pkg::*;
#(
  parameter logic [6:0] GEN_A = GEN_A_DEF,
  parameter logic [6:0] GEN_B = GEN_B_DEF
) (
  input  logic       in_bit_i,
  input  logic [5:0] sr_i,
  output logic       a_o,
  output logic       b_o
);
  logic [6:0] w;
  assign w   = {in_bit_i, sr_i};
  assign a_o = ^(w & GEN_A);
  assign b_o = ^(w & GEN_B);
endmodule

// File: rtl/conv_encoder_punct.sv
// conv_encoder_punct: punctured rate-1/2 K=7 encoder; in_valid/in_ready/in_bit/in_first/in_last/rate in, out_valid/out_ready/out_bit/out_last serial out
module conv_encoder_punct
  import conv_encoder_punct_pkg::*;
#(
  parameter logic [6:0] GEN_A = GEN_A_DEF,
  parameter logic [6:0] GEN_B = GEN_B_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] rate,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       in_bit,
  input  logic       in_first,
  input  logic       in_last,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_bit,
  output logic       out_last
);
  logic [5:0] sr_q, sr_d, sr_cur;
  logic [1:0] ph_q, ph_d, ph_cur;
  logic [1:0] rate_q, rate_d, rate_cur;
  logic [1:0] cnt_q, cnt_d;
  logic [1:0] dat_q, dat_d;
  logic [1:0] last_q, last_d;
  logic       accept, pop, a, b;
  punct_t     pm;
  assign accept    = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign in_ready  = (cnt_q == 2'd0) | ((cnt_q == 2'd1) & out_ready);
  assign out_valid = cnt_q != 2'd0;
  assign out_bit   = dat_q[0];
  assign out_last  = last_q[0];
  // in_first restarts the frame: encode from zero state with the freshly sampled rate
  assign sr_cur   = in_first ? 6'd0 : sr_q;
  assign ph_cur   = in_first ? 2'd0 : ph_q;
  assign rate_cur = in_first ? rate_norm(rate) : rate_q;
  assign pm       = punct_lookup(rate_cur, ph_cur);
  conv_enc_core #(.GEN_A(GEN_A), .GEN_B(GEN_B)) u_core (
    .in_bit_i(in_bit),
    .sr_i    (sr_cur),
    .a_o     (a),
    .b_o     (b)
  );
  // accept is only possible when the buffer is empty after this cycle's pop, so a load overwrites both slots
  always_comb begin
    sr_d   = sr_q;
    ph_d   = ph_q;
    rate_d = rate_q;
    cnt_d  = pop ? cnt_q - 2'd1 : cnt_q;
    dat_d  = pop ? {1'b0, dat_q[1]} : dat_q;
    last_d = pop ? {1'b0, last_q[1]} : last_q;
    if (accept) begin
      sr_d   = {in_bit, sr_cur[5:1]};
      ph_d   = ph_next(rate_cur, ph_cur);
      rate_d = rate_cur;
      cnt_d  = {1'b0, pm.emit_a} + {1'b0, pm.emit_b};
      dat_d  = {b, pm.emit_a ? a : b};
      last_d = (pm.emit_a & pm.emit_b) ? {in_last, 1'b0} : {1'b0, in_last};
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr_q   <= '0;
      ph_q   <= '0;
      rate_q <= RATE_1_2;
      cnt_q  <= '0;
      dat_q  <= '0;
      last_q <= '0;
    end else begin
      sr_q   <= sr_d;
      ph_q   <= ph_d;
      rate_q <= rate_d;
      cnt_q  <= cnt_d;
      dat_q  <= dat_d;
      last_q <= last_d;
    end
  end
endmodule
